// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  localparam int unsigned TAG_AW = 5;
  localparam int unsigned FWD_RF = 0;
  localparam int unsigned REG_X0 = 0;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              regwen;
    logic              is_load;
  } pipe_tag_t;

  // True when the tag will update a real architectural register (x0 excluded).
  function automatic logic tag_writes(pipe_tag_t t);
    return t.valid && t.regwen && (t.rd != TAG_AW'(REG_X0));
  endfunction

endpackage

// File: rtl/pipe_tag_stage.sv
// One in-flight destination tag: async clear, hold keeps the tag, bubble loads an empty tag.
module pipe_tag_stage
  import pipe_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  logic      bubble,
  input  pipe_tag_t d,
  output pipe_tag_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         q <= '0;
    else if (!hold)   q <= bubble ? pipe_tag_t'('0) : d;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush control for an NSTAGE-deep RV32I pipeline.
// Define PIPE_HAZARD_CTRL_PERF_EN to add stall/flush/retire performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned FW     = $clog2(NSTAGE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_valid,
  input  logic [REG_AW-1:0] f_rd,
  input  logic [REG_AW-1:0] f_rs1,
  input  logic [REG_AW-1:0] f_rs2,
  input  logic              f_regwen,
  input  logic              f_is_load,
  input  logic              f_use_rs1,
  input  logic              f_use_rs2,
  input  logic              redirect,
  output logic              stall_o,
  output logic              flush_o,
  output logic              bubble_o,
  output logic [FW-1:0]     fwd_a_sel,
  output logic [FW-1:0]     fwd_b_sel,
  output logic              wb_en_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic [NSTAGE-2:0] stage_valid_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_flush_o,
  output logic [31:0]       perf_retire_o
`endif
);

  pipe_tag_t         tag_q [1:NSTAGE-1];
  logic [TAG_AW-1:0] rs1_q, rs2_q;
  logic              use_rs1_q, use_rs2_q;
  logic [FW-1:0]     sel_a, sel_b;
  logic              ld_a, ld_b;
  logic              need_a, need_b;

  // Tag chain: X holds on stall, stage 2 takes a bubble on stall, older stages always advance.
  for (genvar g = 1; g < NSTAGE; g++) begin : g_stage
    pipe_tag_t d;
    logic      hold;
    logic      bubble;
    if (g == 1) begin : g_x
      assign d      = '{valid: f_valid & ~flush_o, rd: TAG_AW'(f_rd),
                        regwen: f_regwen, is_load: f_is_load};
      assign hold   = stall_o;
      assign bubble = 1'b0;
    end else begin : g_older
      assign d      = tag_q[g-1];
      assign hold   = 1'b0;
      assign bubble = (g == 2) ? stall_o : 1'b0;
    end
    pipe_tag_stage u_tag (
      .clk    (clk),
      .rst    (rst),
      .hold   (hold),
      .bubble (bubble),
      .d      (d),
      .q      (tag_q[g])
    );
    assign stage_valid_o[g-1] = tag_q[g].valid;
  end

  // Source operands of the X instruction, held together with its tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
    end else if (!stall_o) begin
      rs1_q     <= TAG_AW'(f_rs1);
      rs2_q     <= TAG_AW'(f_rs2);
      use_rs1_q <= f_use_rs1;
      use_rs2_q <= f_use_rs2;
    end
  end

  // Scan oldest to youngest so the youngest matching producer is left in sel_*/ld_*.
  always_comb begin
    sel_a = FW'(FWD_RF);
    sel_b = FW'(FWD_RF);
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    for (int s = int'(NSTAGE) - 1; s >= 2; s--) begin
      if (tag_writes(tag_q[s]) && (tag_q[s].rd == rs1_q)) begin
        sel_a = FW'(s);
        ld_a  = tag_q[s].is_load && (s != int'(NSTAGE) - 1);
      end
      if (tag_writes(tag_q[s]) && (tag_q[s].rd == rs2_q)) begin
        sel_b = FW'(s);
        ld_b  = tag_q[s].is_load && (s != int'(NSTAGE) - 1);
      end
    end
  end

  // A bubble in X never consumes operands, so it cannot forward or stall.
  assign need_a    = tag_q[1].valid & use_rs1_q;
  assign need_b    = tag_q[1].valid & use_rs2_q;
  assign stall_o   = (need_a & ld_a) | (need_b & ld_b);
  assign bubble_o  = stall_o;
  assign flush_o   = redirect & ~stall_o & tag_q[1].valid;
  assign fwd_a_sel = (need_a && !ld_a) ? sel_a : FW'(FWD_RF);
  assign fwd_b_sel = (need_b && !ld_b) ? sel_b : FW'(FWD_RF);
  assign wb_en_o   = tag_writes(tag_q[NSTAGE-1]);
  assign wb_rd_o   = REG_AW'(tag_q[NSTAGE-1].rd);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_o  <= '0;
      perf_flush_o  <= '0;
      perf_retire_o <= '0;
    end else begin
      if (stall_o && (perf_stall_o != '1))                  perf_stall_o  <= perf_stall_o + 32'd1;
      if (flush_o && (perf_flush_o != '1))                  perf_flush_o  <= perf_flush_o + 32'd1;
      if (tag_q[NSTAGE-1].valid && (perf_retire_o != '1))   perf_retire_o <= perf_retire_o + 32'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: NSTAGE=3 and NSTAGE=5 controllers driven by shared stimulus and an instruction-level model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       f_valid;
  logic [4:0] f_rd, f_rs1, f_rs2;
  logic       f_regwen, f_is_load, f_use_rs1, f_use_rs2;
  logic       redirect;

  logic       stall3, flush3, bubble3, wben3;
  logic [1:0] fa3, fb3;
  logic [4:0] wbrd3;
  logic [1:0] sv3;
  logic       stall5, flush5, bubble5, wben5;
  logic [2:0] fa5, fb5;
  logic [4:0] wbrd5;
  logic [3:0] sv5;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] ps3, pf3, pr3, ps5, pf5, pr5;
`endif

  pipe_hazard_ctrl #(.NSTAGE(3)) dut3 (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_rd(f_rd), .f_rs1(f_rs1), .f_rs2(f_rs2),
    .f_regwen(f_regwen), .f_is_load(f_is_load), .f_use_rs1(f_use_rs1), .f_use_rs2(f_use_rs2),
    .redirect(redirect), .stall_o(stall3), .flush_o(flush3), .bubble_o(bubble3),
    .fwd_a_sel(fa3), .fwd_b_sel(fb3), .wb_en_o(wben3), .wb_rd_o(wbrd3), .stage_valid_o(sv3)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .perf_stall_o(ps3), .perf_flush_o(pf3), .perf_retire_o(pr3)
`endif
  );

  pipe_hazard_ctrl #(.NSTAGE(5)) dut5 (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_rd(f_rd), .f_rs1(f_rs1), .f_rs2(f_rs2),
    .f_regwen(f_regwen), .f_is_load(f_is_load), .f_use_rs1(f_use_rs1), .f_use_rs2(f_use_rs2),
    .redirect(redirect), .stall_o(stall5), .flush_o(flush5), .bubble_o(bubble5),
    .fwd_a_sel(fa5), .fwd_b_sel(fb5), .wb_en_o(wben5), .wb_rd_o(wbrd5), .stage_valid_o(sv5)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .perf_stall_o(ps5), .perf_flush_o(pf5), .perf_retire_o(pr5)
`endif
  );

  typedef struct {
    bit valid;
    int rd;
    bit regwen;
    bit is_load;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
  } ins_t;

  typedef struct {
    bit stall;
    bit flush;
    bit bubble;
    bit chk_fwd;
    bit wb_en;
    int fa;
    int fb;
    int wb_rd;
    int sv;
  } exp_t;

  ins_t mp [2][5];   // per model: instruction occupying stage 1..N-1
  ins_t nop_i;       // never written: all-zero empty slot
  exp_t q0[$], q1[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int nst(int d);
    return (d == 0) ? 3 : 5;
  endfunction

  function automatic bit writes(ins_t i);
    return i.valid && i.regwen && (i.rd != 0);
  endfunction

  function automatic ins_t mk(bit v, int rd, int rs1, int rs2, bit we, bit ld, bit u1, bit u2);
    ins_t i;
    i.valid = v; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.regwen = we; i.is_load = ld; i.u1 = u1; i.u2 = u2;
    return i;
  endfunction

  // Nearest older producer of rs decides: usable result -> its stage, unfinished load -> stall.
  function automatic void operand(int d, int rs, bit use_it, output int sel, output bit st);
    sel = 0;
    st  = 0;
    if (mp[d][1].valid && use_it) begin
      for (int s = 2; s < nst(d); s++) begin
        if (writes(mp[d][s]) && mp[d][s].rd == rs) begin
          st = mp[d][s].is_load && (s < nst(d) - 1);
          if (!st) sel = s;
          break;
        end
      end
    end
  endfunction

  function automatic exp_t predict(int d, bit redir);
    exp_t e;
    int   fa, fb;
    bit   sa, sb;
    operand(d, mp[d][1].rs1, mp[d][1].u1, fa, sa);
    operand(d, mp[d][1].rs2, mp[d][1].u2, fb, sb);
    e.stall   = sa || sb;
    e.bubble  = e.stall;
    e.flush   = redir && !e.stall && mp[d][1].valid;
    e.fa      = fa;
    e.fb      = fb;
    e.chk_fwd = mp[d][1].valid && !e.stall;
    e.wb_en   = writes(mp[d][nst(d)-1]);
    e.wb_rd   = mp[d][nst(d)-1].rd;
    e.sv      = 0;
    for (int s = 1; s < nst(d); s++) if (mp[d][s].valid) e.sv |= (1 << (s - 1));
    return e;
  endfunction

  function automatic void advance(int d, ins_t f, exp_t e);
    for (int s = nst(d) - 1; s >= 3; s--) mp[d][s] = mp[d][s-1];
    if (e.stall) begin
      mp[d][2] = nop_i;
    end else begin
      mp[d][2] = mp[d][1];
      mp[d][1] = f;
      mp[d][1].valid = f.valid && !e.flush;
    end
  endfunction

  function automatic void reset_model();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 5; s++) mp[d][s] = nop_i;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(string t, exp_t e, int st, int fl, int bu, int fa, int fb,
                           int we, int wr, int sv);
    chk({t, " stall"}, st, int'(e.stall));
    chk({t, " flush"}, fl, int'(e.flush));
    chk({t, " bubble"}, bu, int'(e.bubble));
    if (e.chk_fwd) begin
      chk({t, " fwd_a"}, fa, e.fa);
      chk({t, " fwd_b"}, fb, e.fb);
    end
    chk({t, " wb_en"}, we, int'(e.wb_en));
    if (e.wb_en) chk({t, " wb_rd"}, wr, e.wb_rd);
    chk({t, " stage_valid"}, sv, e.sv);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check_dut("n3", e, stall3, flush3, bubble3, fa3, fb3, wben3, wbrd3, sv3);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check_dut("n5", e, stall5, flush5, bubble5, fa5, fb5, wben5, wbrd5, sv5);
      end
    end
  endtask

  task automatic drive_set(ins_t f, bit r);
    exp_t e;
    f_valid = f.valid;  f_rd = 5'(f.rd);  f_rs1 = 5'(f.rs1);  f_rs2 = 5'(f.rs2);
    f_regwen = f.regwen;  f_is_load = f.is_load;  f_use_rs1 = f.u1;  f_use_rs2 = f.u2;
    redirect = r;
    for (int d = 0; d < 2; d++) begin
      e = predict(d, r);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      advance(d, f, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(ins_t f, bit r);
    drive_set(f, r);
    step();
  endtask

  task automatic reset_checks(string t);
    chk({t, " n3 stall"}, stall3, 0);  chk({t, " n3 flush"}, flush3, 0);
    chk({t, " n3 bubble"}, bubble3, 0); chk({t, " n3 wb_en"}, wben3, 0);
    chk({t, " n3 fwd_a"}, fa3, 0);     chk({t, " n3 fwd_b"}, fb3, 0);
    chk({t, " n3 valid"}, sv3, 0);
    chk({t, " n5 stall"}, stall5, 0);  chk({t, " n5 flush"}, flush5, 0);
    chk({t, " n5 bubble"}, bubble5, 0); chk({t, " n5 wb_en"}, wben5, 0);
    chk({t, " n5 fwd_a"}, fa5, 0);     chk({t, " n5 fwd_b"}, fb5, 0);
    chk({t, " n5 valid"}, sv5, 0);
  endtask

  function automatic ins_t rand_ins();
    bit we;
    we = ($urandom % 10) < 7;
    return mk(($urandom % 10) < 8, int'($urandom % 8), int'($urandom % 8), int'($urandom % 8),
              we, we && (($urandom % 10) < 3), ($urandom % 10) < 6, ($urandom % 10) < 6);
  endfunction

  task automatic flush_pipe();
    repeat (5) drive(nop_i, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    f_valid = 1'b1; f_rd = 5'd3; f_rs1 = 5'd3; f_rs2 = 5'd3;
    f_regwen = 1'b1; f_is_load = 1'b1; f_use_rs1 = 1'b1; f_use_rs2 = 1'b1;
    redirect = 1'b1;
    reset_model();
    fork monitor(); join_none

    // Reset held with live F input: everything stays quiet.
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b1;
    drive_set(mk(1, 3, 1, 2, 1, 0, 0, 0), 1'b0);
    #1;
    chk("pre-edge n3 valid", sv3, 0);
    step();
    chk("first edge n3 x valid", int'(sv3[0]), 1);
    chk("first edge n5 x valid", int'(sv5[0]), 1);

    // ALU RAW: add x5 then sub reading x5.
    flush_pipe();
    drive(mk(1, 5, 1, 2, 1, 0, 1, 1), 1'b0);
    drive(mk(1, 6, 5, 3, 1, 0, 1, 1), 1'b0);
    drive_set(nop_i, 1'b0);
    #1;
    chk("raw n3 fwd_a", fa3, 2);
    chk("raw n5 fwd_a", fa5, 2);
    chk("raw n3 wb_en", wben3, 1);
    chk("raw n3 wb_rd", wbrd3, 5);
    step();

    // Load-use: lw x7 then add reading x7 on rs2.
    flush_pipe();
    drive(mk(1, 7, 1, 2, 1, 1, 1, 0), 1'b0);
    drive(mk(1, 8, 3, 7, 1, 0, 1, 1), 1'b0);
    drive_set(nop_i, 1'b0);
    #1;
    chk("lu n5 stall c1", stall5, 1);
    chk("lu n5 bubble c1", bubble5, 1);
    chk("lu n3 stall", stall3, 0);
    chk("lu n3 fwd_b", fb3, 2);
    step();
    drive_set(nop_i, 1'b0);
    #1;
    chk("lu n5 stall c2", stall5, 1);
    chk("lu n5 bubble c2", bubble5, 1);
    step();
    drive_set(nop_i, 1'b0);
    #1;
    chk("lu n5 stall c3", stall5, 0);
    chk("lu n5 fwd_b", fb5, 4);
    step();

    // x0 never forwards nor writes back.
    flush_pipe();
    drive(mk(1, 0, 1, 0, 1, 0, 1, 0), 1'b0);
    drive(mk(1, 9, 0, 0, 1, 0, 1, 1), 1'b0);
    drive_set(nop_i, 1'b0);
    #1;
    chk("x0 n3 fwd_a", fa3, 0);
    chk("x0 n5 fwd_a", fa5, 0);
    chk("x0 n3 wb_en", wben3, 0);
    step();

    // Qualified redirect squashes the F instruction.
    flush_pipe();
    drive(mk(1, 10, 1, 2, 1, 0, 0, 0), 1'b0);
    drive_set(mk(1, 11, 1, 2, 1, 0, 0, 0), 1'b1);
    #1;
    chk("redir n3 flush", flush3, 1);
    chk("redir n5 flush", flush5, 1);
    step();
    chk("redir n3 x bubble", int'(sv3[0]), 0);
    chk("redir n5 x bubble", int'(sv5[0]), 0);

    // Redirect during a load-use stall is dropped on the 5-stage pipe.
    flush_pipe();
    drive(mk(1, 7, 1, 2, 1, 1, 1, 0), 1'b0);
    drive(mk(1, 8, 7, 3, 1, 0, 1, 1), 1'b0);
    drive_set(mk(1, 12, 1, 2, 1, 0, 0, 0), 1'b1);
    #1;
    chk("stall-redir n5 flush", flush5, 0);
    chk("stall-redir n3 flush", flush3, 1);
    step();
    chk("stall-redir n5 x held", int'(sv5[0]), 1);
    chk("stall-redir n5 still stalled", stall5, 1);
    chk("stall-redir n3 x bubble", int'(sv3[0]), 0);
    flush_pipe();

    // Random traffic.
    for (int i = 0; i < 400; i++) drive(rand_ins(), ($urandom % 100) < 15);

    // Asynchronous reset mid-stream.
    rst = 1'b0;
    #1;
    reset_checks("async");
    reset_model();
    step();
    rst = 1'b1;
    for (int i = 0; i < 150; i++) drive(rand_ins(), ($urandom % 100) < 15);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
